// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: tx_en/tx_done handshake, one byte per frame.
// Optional level output and low-watermark interrupt: define UART_TXFIFO_LEVEL_EN.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int LOW_WM = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       wr_valid_i,
  input  logic [7:0]                 wr_data_i,
  output logic                       wr_ready_o,
  input  logic                       flush_i,
  output logic                       tx_en_o,
  output logic [7:0]                 tx_data_o,
  input  logic                       tx_done_i,
  output logic                       busy_o,
  output logic                       empty_o,
  output logic                       full_o
`ifdef UART_TXFIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       lvl_irq_o
`endif
);

  // state   | meaning
  // IDLE    | no byte in flight; issues the head byte when the FIFO is non-empty
  // WAIT_HI | byte issued, waiting for tx_done_i to rise
  // WAIT_LO | done seen, waiting for tx_done_i to fall (transmitter back to idle)
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    WAIT_LO = 2'd2
  } state_t;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          wr_fire;
  logic          pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign wr_ready_o = ~full & ~flush_i;
  assign wr_fire    = wr_valid_i & wr_ready_o;
  assign pop        = (state == IDLE) & ~empty & ~flush_i;

  assign empty_o = empty;
  assign full_o  = full;
  assign busy_o  = (state != IDLE) | ~empty;

  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      mem[wr_ptr[AW-1:0]] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + CW'(1);
      end
      // Flush drops everything queued; a byte already issued is unaffected.
      if (flush_i) begin
        rd_ptr <= wr_ptr;
      end else if (pop) begin
        rd_ptr <= rd_ptr + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      tx_en_o   <= 1'b0;
      tx_data_o <= 8'h00;
    end else begin
      tx_en_o <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            tx_en_o   <= 1'b1;
            tx_data_o <= mem[rd_ptr[AW-1:0]];
            state     <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (tx_done_i) begin
            state <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (!tx_done_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_TXFIFO_LEVEL_EN
  assign level_o   = wr_ptr - rd_ptr;
  assign lvl_irq_o = (level_o <= CW'(LOW_WM));
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations. Honours UART_TXFIFO_LEVEL_EN.
module tb_uart_tx_fifo;
  localparam int DEPTH  = 16;
  localparam int LOW_WM = 2;
  localparam int CW     = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       flush = 1'b0;
  logic       tx_done = 1'b0;
  logic       wr_ready, tx_en, busy, empty, full;
  logic [7:0] tx_data;
`ifdef UART_TXFIFO_LEVEL_EN
  logic [CW-1:0] level;
  logic          lvl_irq;
`endif

  uart_tx_fifo #(.DEPTH(DEPTH), .LOW_WM(LOW_WM)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .wr_valid_i (wr_valid),
    .wr_data_i  (wr_data),
    .wr_ready_o (wr_ready),
    .flush_i    (flush),
    .tx_en_o    (tx_en),
    .tx_data_o  (tx_data),
    .tx_done_i  (tx_done),
    .busy_o     (busy),
    .empty_o    (empty),
    .full_o     (full)
`ifdef UART_TXFIFO_LEVEL_EN
    ,
    .level_o    (level),
    .lvl_irq_o  (lvl_irq)
`endif
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus the two handshake phases of an issued byte.
  logic [7:0] q[$];
  bit         m_wait_rise = 0;
  bit         m_wait_fall = 0;
  logic       m_tx_en = 1'b0;
  logic [7:0] m_tx_data = 8'h00;
  bit         m_pop, m_take;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q.delete();
      m_wait_rise = 0;
      m_wait_fall = 0;
      m_tx_en     = 1'b0;
      m_tx_data   = 8'h00;
    end else begin
      m_pop  = !m_wait_rise && !m_wait_fall && (q.size() != 0) && !flush;
      m_take = wr_valid && (q.size() < DEPTH) && !flush;
      m_tx_en = m_pop;
      if (m_pop) m_tx_data = q[0];
      if (m_wait_rise && tx_done) begin
        m_wait_rise = 0;
        m_wait_fall = 1;
      end else if (m_wait_fall && !tx_done) begin
        m_wait_fall = 0;
      end
      if (m_pop) m_wait_rise = 1;
      if (flush) q.delete();
      else begin
        if (m_pop) void'(q.pop_front());
        if (m_take) q.push_back(wr_data);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("tx_en",    32'(tx_en),    32'(m_tx_en));
    chk("tx_data",  32'(tx_data),  32'(m_tx_data));
    chk("wr_ready", 32'(wr_ready), 32'((q.size() < DEPTH) && !flush));
    chk("empty",    32'(empty),    32'(q.size() == 0));
    chk("full",     32'(full),     32'(q.size() == DEPTH));
    chk("busy",     32'(busy),     32'(m_wait_rise || m_wait_fall || (q.size() != 0)));
`ifdef UART_TXFIFO_LEVEL_EN
    chk("level",    32'(level),    32'(q.size()));
    chk("lvl_irq",  32'(lvl_irq),  32'(q.size() <= LOW_WM));
`endif
  end

  logic [7:0] cap[$];
  int         pulses = 0;
  initial forever begin
    @(negedge clk);
    if (tx_en === 1'b1) begin
      cap.push_back(tx_data);
      pulses++;
    end
  end

  // Transmitter stand-in: tx_done high for 2 cycles, 3 cycles after a start or a kick.
  bit auto_en  = 1;
  int kick_req = 0;
  int kick_ack = 0;
  int lat_cnt  = 0;
  int hi_cnt   = 0;
  initial forever begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      lat_cnt  = 0;
      hi_cnt   = 0;
      tx_done  = 1'b0;
      kick_ack = kick_req;
    end else begin
      if ((tx_en && auto_en) || (kick_req != kick_ack)) begin
        kick_ack = kick_req;
        lat_cnt  = 3;
      end else if (lat_cnt != 0) begin
        lat_cnt--;
        if (lat_cnt == 0) hi_cnt = 2;
      end
      tx_done = (hi_cnt != 0);
      if (hi_cnt != 0) hi_cnt--;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    bit ok;
    int n;
    ok = 0;
    n  = 0;
    wr_valid = 1'b1;
    wr_data  = d;
    while (!ok && n < 500) begin
      @(negedge clk);
      if (wr_ready === 1'b1) ok = 1;
      n++;
    end
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    chk("push_ready", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < budget) begin
      tick(1);
      k++;
    end
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tx_en"},    32'(tx_en),    32'd0);
    chk({tag, "_tx_data"},  32'(tx_data),  32'd0);
    chk({tag, "_busy"},     32'(busy),     32'd0);
    chk({tag, "_empty"},    32'(empty),    32'd1);
    chk({tag, "_full"},     32'(full),     32'd0);
    chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
`ifdef UART_TXFIFO_LEVEL_EN
    chk({tag, "_level"},    32'(level),    32'd0);
    chk({tag, "_lvl_irq"},  32'(lvl_irq),  32'd1);
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int p0;
    logic [9:0] line;
    tick(2);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    tick(2);

    // Single byte latency and frame content.
    auto_en = 1;
    push(8'hA5);
    chk("t1_no_early_en", 32'(tx_en), 32'd0);
    tick(1);
    chk("t1_en_k1",   32'(tx_en),   32'd1);
    chk("t1_data_k1", 32'(tx_data), 32'hA5);
    tick(1);
    chk("t1_en_k2",   32'(tx_en),   32'd0);
    wait_idle(100);
    chk("t1_pulses", 32'(pulses), 32'd1);
    line = {1'b1, cap[0], 1'b0};
    chk("t1_line", 32'(line), 32'(10'b1101001010));
    chk("t1_data_hold", 32'(tx_data), 32'hA5);

    // Fill to full behind a stalled frame, hold a write across full, then drain in order.
    auto_en = 0;
    cap.delete();
    push(8'hEE);
    tick(2);
    for (int i = 0; i < 16; i++) push(8'(i));
    chk("t2_full",     32'(full),     32'd1);
    chk("t2_wr_ready", 32'(wr_ready), 32'd0);
    p0 = pulses;
    wr_valid = 1'b1;
    wr_data  = 8'h77;
    tick(40);
    chk("t2_still_full", 32'(full), 32'd1);
    chk("t2_no_timeout", 32'(busy), 32'd1);
    chk("t2_stalled",    32'(pulses - p0), 32'd0);
    auto_en = 1;
    kick_req++;
    push(8'h77);
    wait_idle(3000);
    chk("t2_empty",   32'(empty), 32'd1);
    chk("t2_cap_cnt", 32'(cap.size()), 32'd18);
    if (cap.size() == 18) begin
      chk("t2_cap_first", 32'(cap[0]), 32'hEE);
      for (int i = 0; i < 16; i++) chk("t2_cap_order", 32'(cap[i+1]), 32'(i));
      chk("t2_cap_last", 32'(cap[17]), 32'h77);
    end

    // One done pulse with two bytes queued releases exactly one more byte.
    auto_en = 0;
    p0 = pulses;
    push(8'h31);
    push(8'h32);
    push(8'h33);
    tick(2);
    kick_req++;
    tick(30);
    chk("t3_one_extra", 32'(pulses - p0), 32'd2);
    chk("t3_one_left",  32'(empty), 32'd0);
    chk("t3_data",      32'(tx_data), 32'h32);
    auto_en = 1;
    kick_req++;
    wait_idle(200);
    chk("t3_total", 32'(pulses - p0), 32'd3);

    // Flush while a byte is in flight: queue dropped, write dropped, frame completes.
    auto_en = 0;
    p0 = pulses;
    for (int i = 0; i < 6; i++) push(8'h40 + 8'(i));
    tick(2);
    flush    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'h99;
    tick(1);
    flush    = 1'b0;
    wr_valid = 1'b0;
    chk("t4_empty", 32'(empty), 32'd1);
    chk("t4_busy",  32'(busy),  32'd1);
    kick_req++;
    wait_idle(200);
    tick(20);
    chk("t4_pulses", 32'(pulses - p0), 32'd1);
    chk("t4_empty2", 32'(empty), 32'd1);

    // Asynchronous reset mid-frame with three bytes queued.
    auto_en = 0;
    for (int i = 0; i < 4; i++) push(8'h61 + 8'(i));
    tick(2);
    chk("t5_pre_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("t5");
    tick(2);
    rst_n = 1'b1;
    p0 = pulses;
    tick(20);
    chk("t5_no_en", 32'(pulses - p0), 32'd0);
    auto_en = 1;
    push(8'h5A);
    wait_idle(200);
    chk("t5_new_pulse", 32'(pulses - p0), 32'd1);
    chk("t5_new_data",  32'(tx_data), 32'h5A);

`ifdef UART_TXFIFO_LEVEL_EN
    // Level and low-watermark interrupt.
    begin
      int k;
      auto_en = 0;
      for (int i = 0; i < 5; i++) push(8'h70 + 8'(i));
      tick(2);
      chk("t6_level4", 32'(level),   32'd4);
      chk("t6_irq0",   32'(lvl_irq), 32'd0);
      auto_en = 1;
      kick_req++;
      k = 0;
      while (level !== 5'd2 && k < 500) begin
        tick(1);
        k++;
      end
      chk("t6_level2", 32'(level),   32'd2);
      chk("t6_irq1",   32'(lvl_irq), 32'd1);
      wait_idle(300);
    end
`endif

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
